// File: rtl/fault_adder_pkg.sv
// Shared constants and types for the fault-injectable ripple-carry adder.
// Imported by the leaf cells, the top and the bench.
package fault_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Full unsigned result of a DEFAULT_WIDTH-bit add: {carry-out, sum bits}.
    typedef logic [DEFAULT_WIDTH:0] result_t;

endpackage

// File: rtl/full_adder.sv
// Correct one-bit full-adder cell: sum and majority carry-out.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/incorr_full_adder.sv
// Deliberately faulty one-bit cell: the sum is correct but carry propagation
// is dropped, so cout only reflects carry generation (a & b).
module incorr_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = a & b;

endmodule

// File: rtl/fault_full_adder.sv
// Two-stage registered ripple-carry adder built from one-bit cells.
// Defining FAULT_INJECT_EN replaces cell FAULT_BIT with incorr_full_adder.
module fault_full_adder
    import fault_adder_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int FAULT_BIT = WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH:0]   sum
);

    if (FAULT_BIT < 0 || FAULT_BIT >= WIDTH) begin : g_bad_fault_bit
        $error("fault_full_adder: FAULT_BIT out of range 0..WIDTH-1");
    end

    // Stage 1: operand capture.
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             cin_q, cin_d;
    logic             valid_q, valid_d;

    // Stage 2: registered result.
    logic [WIDTH:0]   sum_q, sum_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_bits;

    // NOTE: every _d gets its hold value first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        valid_d = in_valid;
        if (in_valid) begin
            a_d   = a;
            b_d   = b;
            cin_d = cin;
        end
    end

    assign carry[0] = cin_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
`ifdef FAULT_INJECT_EN
        if (i == FAULT_BIT) begin : g_faulty
            incorr_full_adder u_cell (
                .a    (a_q[i]),
                .b    (b_q[i]),
                .cin  (carry[i]),
                .sum  (sum_bits[i]),
                .cout (carry[i+1])
            );
        end else begin : g_correct
            full_adder u_cell (
                .a    (a_q[i]),
                .b    (b_q[i]),
                .cin  (carry[i]),
                .sum  (sum_bits[i]),
                .cout (carry[i+1])
            );
        end
`else
        full_adder u_cell (
            .a    (a_q[i]),
            .b    (b_q[i]),
            .cin  (carry[i]),
            .sum  (sum_bits[i]),
            .cout (carry[i+1])
        );
`endif
    end

    always_comb begin
        sum_d       = sum_q;
        out_valid_d = valid_q;
        if (valid_q) begin
            sum_d = {carry[WIDTH], sum_bits};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            valid_q     <= 1'b0;
            sum_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            cin_q       <= cin_d;
            valid_q     <= valid_d;
            sum_q       <= sum_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sum       = sum_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fault_full_adder.sv
// Self-checking bench for fault_full_adder: arithmetic reference model with a
// per-cycle compare process, plus directed vectors with literal expectations.
module tb_fault_full_adder;
    import fault_adder_pkg::*;

    localparam int W  = DEFAULT_WIDTH;
    localparam int FB = W - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    result_t      sum;

    int n_checks = 0;
    int n_fail   = 0;

    fault_full_adder #(.WIDTH(W), .FAULT_BIT(FB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .sum       (sum)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result from plain arithmetic. With fault injection the bits
    // below FB are exact, the carry out of bit FB is only a[FB]&b[FB], and the
    // upper bits add that carry.
    function automatic int model_add(input int av, input int bv, input int cv);
        int exact;
        int lo_mask;
        int cout_fb;
        exact = av + bv + cv;
`ifdef FAULT_INJECT_EN
        lo_mask = (1 << (FB + 1)) - 1;
        cout_fb = ((av >> FB) & 1) & ((bv >> FB) & 1);
        return (exact & lo_mask) + (((av >> (FB + 1)) + (bv >> (FB + 1)) + cout_fb) << (FB + 1));
`else
        lo_mask = 0;
        cout_fb = 0;
        return exact + lo_mask + cout_fb;
`endif
    endfunction

    // Two-edge delay model: whatever is presented at one edge appears at the
    // output after the next edge; the sum holds when nothing valid arrives.
    logic  pend_v = 1'b0;
    int    pend_r = 0;
    logic  exp_valid = 1'b0;
    int    exp_sum = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_v    <= 1'b0;
            pend_r    <= 0;
            exp_valid <= 1'b0;
            exp_sum   <= 0;
        end else begin
            exp_valid <= pend_v;
            if (pend_v) exp_sum <= pend_r;
            pend_v <= in_valid;
            pend_r <= model_add(int'(a), int'(b), int'(cin));
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("cmp_out_valid", 32'(out_valid), 32'(exp_valid));
            check("cmp_sum", 32'(sum), 32'(exp_sum));
        end
    end

    task automatic drive(input int av, input int bv, input int cv);
        a        = W'(av);
        b        = W'(bv);
        cin      = cv[0];
        in_valid = 1'b1;
    endtask

    // Single operation: result must appear two edges after in_valid, pulse
    // out_valid for one cycle and then hold while operands change.
    task automatic op_check(input string name, input int av, input int bv, input int cv, input int exp);
        drive(av, bv, cv);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        check({name, "_early_valid"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_sum"}, 32'(sum), 32'(exp));
        @(posedge clk); #1;
        check({name, "_pulse"}, 32'(out_valid), 32'd0);
        check({name, "_hold"}, 32'(sum), 32'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_valid", 32'(out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        // Literal expectations pin the model as well as the DUT.
        check("model_100_27", 32'(model_add(100, 27, 0)), 32'd127);
`ifdef FAULT_INJECT_EN
        check("model_255_1", 32'(model_add(255, 1, 0)), 32'd0);
`else
        check("model_255_1", 32'(model_add(255, 1, 0)), 32'd256);
`endif
        check("model_255_255_1", 32'(model_add(255, 255, 1)), 32'd511);

        op_check("add_100_27", 100, 27, 0, 127);
`ifdef FAULT_INJECT_EN
        op_check("add_255_1", 255, 1, 0, 0);
`else
        op_check("add_255_1", 255, 1, 0, 256);
`endif
        op_check("add_128_128", 128, 128, 0, 256);
        op_check("add_255_255_1", 255, 255, 1, 511);
        op_check("add_0_0_1", 0, 0, 1, 1);

        // Back-to-back: three results on three consecutive cycles.
        drive(0, 0, 1);
        @(posedge clk); #1;
        drive(100, 27, 0);
        @(posedge clk); #1;
        check("b2b_0_valid", 32'(out_valid), 32'd1);
        check("b2b_0_sum", 32'(sum), 32'd1);
        drive(128, 128, 0);
        @(posedge clk); #1;
        check("b2b_1_valid", 32'(out_valid), 32'd1);
        check("b2b_1_sum", 32'(sum), 32'd127);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b_2_valid", 32'(out_valid), 32'd1);
        check("b2b_2_sum", 32'(sum), 32'd256);

        // Idle gap with changing operands: sum holds, out_valid stays low.
        for (int i = 0; i < 3; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            cin = 1'($urandom);
            @(posedge clk); #1;
            check("gap_valid", 32'(out_valid), 32'd0);
            check("gap_hold", 32'(sum), 32'd256);
        end

        // Asynchronous reset mid-cycle discards a pending result.
        drive(50, 50, 0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("midreset_sum", 32'(sum), 32'd0);
        check("midreset_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #4 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post_reset_idle_valid", 32'(out_valid), 32'd0);
            check("post_reset_idle_sum", 32'(sum), 32'd0);
        end
        op_check("first_after_reset", 3, 4, 1, 8);

        // Mixed traffic covered by the per-cycle compare process.
        for (int i = 0; i < 40; i++) begin
            a        = W'($urandom);
            b        = W'($urandom);
            cin      = 1'($urandom);
            in_valid = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fault_full_adder.md
Name: fault_full_adder

Overview:
- Parameterised ripple-carry adder built as a chain of one-bit cells.
- The MSB cell can be a deliberately faulty variant, so fault-detection and test experiments can observe a wrong carry-out.
- Operands are registered on input; result and carry-out are registered on output.
- Used as the arithmetic target in fault-injection and verification studies.

Parameters:
- WIDTH, 8, operand width in bits; result is WIDTH+1 bits.
- FAULT_BIT, WIDTH-1, index of the cell replaced by the faulty cell when the optional feature is compiled in; legal range 0..WIDTH-1.

Ports:
- clk  input  1  single clock; all registers rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and cin are valid this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in to bit 0.
- out_valid  output  1  sum holds a new result.
- sum  output  WIDTH+1  {carry-out, WIDTH sum bits}.

Behaviour:
- Reset (rst_n=0, asynchronous): sum=0, out_valid=0, internal operand registers=0. Takes effect immediately regardless of clk.
- Reset mid-operation discards any pending result. The first valid output after deassertion comes from the first in_valid accepted after deassertion.
- Stage 1: on a clk edge with in_valid=1, capture a, b, cin and set the internal valid flag.
  - in_valid=0 clears the internal valid flag.
  - Captured operands hold their old values when in_valid=0.
- Stage 2: combinational ripple chain over the captured operands.
  - Cell i takes a[i], b[i] and carry c[i]; c[0]=cin; c[i+1] is cell i's cout.
  - sum[WIDTH] = c[WIDTH].
  - sum and out_valid are registered from stage 2.
- Latency: 2 clk edges from in_valid to out_valid. Full throughput, one operation per cycle, no back-pressure.
- sum updates only when the stage-1 valid flag is 1; otherwise it holds its value and out_valid=0.
- Correct cell (full_adder): s = a^b^cin; cout = (a&b)|(a&cin)|(b&cin).
- Faulty cell (incorr_full_adder): s = a^b^cin; cout = a&b, i.e. carry propagation is dropped.
- Wrap-around: none. The WIDTH+1 output always holds the full unsigned result a+b+cin, range 0..2*(2^WIDTH-1)+1.

Optional Feature:
- Macro FAULT_INJECT_EN.
- Defined: cell FAULT_BIT is instantiated as incorr_full_adder; all other cells are full_adder.
- Undefined: every cell is full_adder and the block is an exact adder.
- Ports and latency are identical in both builds.

Decomposition:
- Shared package fault_adder_pkg: default WIDTH constant and a result typedef of WIDTH+1 bits.
- Two leaf sub-modules: full_adder and incorr_full_adder, each a purely combinational one-bit cell with ports a, b, cin, sum, cout.
- The top instantiates one cell per bit through a generate loop, with the FAULT_BIT selection guarded by the macro.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle -> sum=0, out_valid=0 immediately. First out_valid after release is 2 edges after the first in_valid.
- A=100, B=27, CIN=0 -> sum=127 in both builds; out_valid pulses for one cycle.
- A=255, B=1, CIN=0 -> sum=256 without FAULT_INJECT_EN; sum=0 with it (MSB cell a=1, b=0, cin=1 drops the carry).
- A=128, B=128, CIN=0 -> 256 in both builds; A=255, B=255, CIN=1 -> 511 in both builds (a&b=1 at MSB).
- A=0, B=0, CIN=1 -> 1. Back-to-back in_valid on 3 consecutive cycles -> 3 consecutive correct results.
- in_valid=0 gap -> sum holds its prior value, out_valid=0.
